video_timing_gen: RTL
=====================

// Module: video_timing_gen
// PURPOSE
//  Parametrised video timing and pixel-pipeline front end for the HDMI path.
//  - Generates sync, blanking and framebuffer coordinates for any display mode.
//  - Fetches RGB332 pixels over a fixed-latency read port.
//  - Delivers RGB888 plus hsync/vsync/de, cycle-aligned, to the TMDS encoders.
//  - Replaces the hard-coded 640x480 generator; serialisation stays downstream.
// PARAMETERS
//  H_ACTIVE     640  visible pixels per line
//  H_FP         16   horizontal front porch, in pixclk cycles
//  H_SYNC       96   hsync width, in cycles
//  H_BP         48   horizontal back porch, in cycles
//  V_ACTIVE     480  visible lines per frame
//  V_FP         10   vertical front porch, in lines
//  V_SYNC       2    vsync width, in lines
//  V_BP         33   vertical back porch, in lines
//  HSYNC_POL    1    1 = hsync active-high, 0 = active-low
//  VSYNC_POL    1    1 = vsync active-high, 0 = active-low
//  SCALE_SHIFT  2    x = cx>>SCALE_SHIFT, y = cy>>SCALE_SHIFT (pixel replication)
//  RD_LATENCY   1    cycles from rd_en/x/y to valid pixel_data (1..4)
//  EXPAND_MODE  0    0 = zero-fill 332->888; 1 = MSB bit replication
// PORTS
//  pixclk       in   1   pixel clock, all logic on rising edge
//  reset        in   1   asynchronous, active-high
//  pixel_data   in   8   RGB332 {r[2:0],g[2:0],b[1:0]}, valid RD_LATENCY cycles after rd_en
//  x            out  10  framebuffer column being requested
//  y            out  10  framebuffer row being requested
//  rd_en        out  1   high when the current counter position is in the active area
//  red          out  8   pixel red, 0 during blanking
//  green        out  8   pixel green, 0 during blanking
//  blue         out  8   pixel blue, 0 during blanking
//  hsync        out  1   horizontal sync, polarity set by HSYNC_POL
//  vsync        out  1   vertical sync, polarity set by VSYNC_POL
//  de           out  1   data enable (active video)
//  frame_start  out  1   one-cycle pulse, aligned with the first de of each frame
// BEHAVIOUR
//  - Totals and width
//    - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//    - Internal counters cx/cy are 12 bit; H_TOTAL and V_TOTAL must be <= 4096.
//  - Counter sequencing
//    - cx increments every cycle and wraps H_TOTAL-1 -> 0.
//    - cy increments only on a cx wrap, and wraps V_TOTAL-1 -> 0.
//  - Request stage (combinational from cx/cy, stage 0)
//    - rd_en = (cx<H_ACTIVE)&&(cy<V_ACTIVE).
//    - x/y = (cx>>SCALE_SHIFT) and (cy>>SCALE_SHIFT), truncated to 10 bits.
//    - x/y are valid only while rd_en is high.
//  - Sync timing, relative to counters
//    - hsync is active for H_ACTIVE+H_FP <= cx < H_ACTIVE+H_FP+H_SYNC.
//    - vsync uses the same window on cy with the V_ parameters.
//  - Output alignment
//    - active/hs/vs/first flags go through an RD_LATENCY-deep delay line.
//    - At cycle t+RD_LATENCY the register stage captures pixel_data and the
//      delayed flags.
//    - red/green/blue/de/hsync/vsync/frame_start for counter position t
//      appear at t+RD_LATENCY+1: all outputs registered, total latency RD_LATENCY+1.
//  - Colour expansion
//    - Mode 0: red={r,5'b0}, green={g,5'b0}, blue={b,6'b0}.
//    - Mode 1: red={r,r,r[2:1]}, green={g,g,g[2:1]}, blue={b,b,b,b}.
//  - Blanking
//    - When the delayed active flag is 0: red/green/blue = 0 and de = 0,
//      whatever pixel_data is.
//  - frame_start
//    - Asserts for exactly one cycle, coincident with de for position (0,0).
//  - Reset
//    - Asynchronous assert at any time, mid-line or mid-frame.
//    - Clears cx, cy and all delay-line stages.
//    - Outputs go immediately to: rgb=0, de=0, frame_start=0, rd_en=1
//      (cx=cy=0 is active), x=y=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
//    - After release the frame restarts at (0,0); the first de is RD_LATENCY+1 cycles later.
//  - No backpressure: the read port must honour RD_LATENCY exactly, every cycle.
// TESTING
//  1 Reset, defaults: assert reset mid-line -> rgb=0, de=0, hsync=vsync=0; rd_en=1, x=y=0.
//  2 Defaults, free run: hsync high for 96 cycles every 800; its first high is
//    cycle 656+2 after reset release; frame_start period = 420000 cycles.
//  3 Zero-fill (EXPAND_MODE=0), pixel_data=8'hFF for 1 cycle at cx=0,cy=0:
//    red=E0, green=E0, blue=C0 exactly 2 cycles later, with de=1 and frame_start=1.
//  4 Replication (EXPAND_MODE=1), pixel_data=8'b101_011_10 -> red=B6, green=6D, blue=AA.
//  5 Blanking: pixel_data=8'hFF held constant -> rgb=0 whenever de=0; x/y step
//    every 4 cycles/lines, x=0..159, y=0..119.
//  6 Alternate params (H 8/2/2/2, V 4/1/1/1, RD_LATENCY=3, polarities 0):
//    H_TOTAL=14; hsync low at cycles 10..11 of each line plus 4 latency;
//    de high 8 of every 14 cycles; frame_start every 98 cycles.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised sync/blanking generator with fixed-latency RGB332 fetch and RGB888 output
// Ports:
//   pixclk, reset          pixel clock, asynchronous active-high reset
//   pixel_data             RGB332 read data, valid RD_LATENCY cycles after rd_en
//   x, y, rd_en            framebuffer request for the current counter position
//   red, green, blue       RGB888, zero while blanking
//   hsync, vsync, de       sync and data enable, aligned with the colour outputs
//   frame_start            one-cycle pulse with the first de of each frame
module video_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int HSYNC_POL   = 1,
    parameter int VSYNC_POL   = 1,
    parameter int SCALE_SHIFT = 2,
    parameter int RD_LATENCY  = 1,
    parameter int EXPAND_MODE = 0
) (
    input  logic       pixclk,
    input  logic       reset,
    input  logic [7:0] pixel_data,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       rd_en,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] HA  = 12'(H_ACTIVE);
    localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] HL  = 12'(H_TOTAL - 1);
    localparam logic [11:0] VA  = 12'(V_ACTIVE);
    localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] VL  = 12'(V_TOTAL - 1);
    localparam logic HP = 1'(HSYNC_POL);
    localparam logic VP = 1'(VSYNC_POL);

    logic [11:0] cx, cy;
    logic active, hs, vs, first;
    // each stage holds {active, hs, vs, first}
    logic [3:0] dl [RD_LATENCY];
    logic [3:0] d;
    logic [2:0] r, g;
    logic [1:0] b;
    logic [7:0] er, eg, eb;

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            cx <= '0;
            cy <= '0;
        end else begin
            cx <= (cx == HL) ? '0 : cx + 1'b1;
            if (cx == HL)
                cy <= (cy == VL) ? '0 : cy + 1'b1;
        end
    end

    always_comb begin
        active = (cx < HA) && (cy < VA);
        hs     = (cx >= HS0) && (cx < HS1);
        vs     = (cy >= VS0) && (cy < VS1);
        first  = (cx == '0) && (cy == '0);
        rd_en  = active;
        x      = 10'(cx >> SCALE_SHIFT);
        y      = 10'(cy >> SCALE_SHIFT);
        d      = dl[RD_LATENCY-1];
        r      = pixel_data[7:5];
        g      = pixel_data[4:2];
        b      = pixel_data[1:0];
        er     = (EXPAND_MODE != 0) ? {r, r, r[2:1]} : {r, 5'b0};
        eg     = (EXPAND_MODE != 0) ? {g, g, g[2:1]} : {g, 5'b0};
        eb     = (EXPAND_MODE != 0) ? {b, b, b, b}   : {b, 6'b0};
    end

    // flags wait alongside the read so they meet pixel_data at t+RD_LATENCY
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++)
                dl[i] <= '0;
        end else begin
            dl[0] <= {active, hs, vs, first};
            for (int i = 1; i < RD_LATENCY; i++)
                dl[i] <= dl[i-1];
        end
    end

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            de          <= 1'b0;
            hsync       <= ~HP;
            vsync       <= ~VP;
            frame_start <= 1'b0;
        end else begin
            red         <= d[3] ? er : '0;
            green       <= d[3] ? eg : '0;
            blue        <= d[3] ? eb : '0;
            de          <= d[3];
            hsync       <= d[2] ? HP : ~HP;
            vsync       <= d[1] ? VP : ~VP;
            frame_start <= d[0];
        end
    end
endmodule
